if_id_reg: RTL

Fetch-to-decode pipeline register for the five-stage MIPS pipeline. Captures the instruction word and PC+8 produced by the fetch stage each cycle. Supports stall (hold) and flush (bubble insertion), flags fetch-address errors, pre-splits the instruction into its fields for the decode stage, and keeps saturating stall/flush statistics counters.

---
 rtl/if_id_reg.sv | 87 ++++++++
 1 files changed

// File: rtl/if_id_reg.sv
// Fetch-to-decode pipeline register. It supports stall, flush, fetch address
// error tagging, instruction field pre-split, and saturating stall/flush counters.
module if_id_reg #(
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_f,
    input  logic [31:0]      pc8_f,
    input  logic             en,
    input  logic             clr,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc8_d,
    output logic             valid_d,
    output logic             adel_d,
    output logic [5:0]       op_d,
    output logic [4:0]       rs_d,
    output logic [4:0]       rt_d,
    output logic [4:0]       rd_d,
    output logic [4:0]       shamt_d,
    output logic [5:0]       funct_d,
    output logic [15:0]      imm16_d,
    output logic [25:0]      addr26_d,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [31:0]      PC_LAST = PC_BASE + 32'(4 * (IM_WORDS - 1));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] pc_f;
    logic        adel_f;

    // Recover the fetch PC and flag a misaligned or out-of-range fetch
    always_comb begin
        pc_f   = pc8_f - 32'd8;
        adel_f = (pc_f[1:0] != 2'b00) || (pc_f < PC_BASE) || (pc_f > PC_LAST);
    end

    // Pipeline register: flush beats stall, and a faulting fetch forwards a nop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d <= 32'd0;
            pc8_d   <= 32'd0;
            valid_d <= 1'b0;
            adel_d  <= 1'b0;
        end else if (clr) begin
            instr_d <= 32'd0;
            pc8_d   <= pc8_f;
            valid_d <= 1'b0;
            adel_d  <= 1'b0;
        end else if (en) begin
            instr_d <= adel_f ? 32'd0 : instr_f;
            pc8_d   <= pc8_f;
            valid_d <= 1'b1;
            adel_d  <= adel_f;
        end
    end

    // Saturating statistics: held real instructions and accepted flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (clr && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (!clr && !en && valid_d && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // Decode fields are plain slices of the registered instruction
    assign op_d     = instr_d[31:26];
    assign rs_d     = instr_d[25:21];
    assign rt_d     = instr_d[20:16];
    assign rd_d     = instr_d[15:11];
    assign shamt_d  = instr_d[10:6];
    assign funct_d  = instr_d[5:0];
    assign imm16_d  = instr_d[15:0];
    assign addr26_d = instr_d[25:0];

endmodule
